// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port synchronous RAM
// between two requesters, with read data routed back one cycle later.
// Optional feature macro RAM_ARB_INIT_CLEAR_EN: when defined, the RAM is
// zero-filled (one word per cycle) after every reset before arbitration starts.
module ram_port_arbiter #(
    parameter  int unsigned SIZE  = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req0_write,
    input  logic [AW-1:0]   req0_address,
    input  logic [SIZE-1:0] req0_write_data,
    output logic            req0_ready,
    output logic            resp0_valid,
    input  logic            req1_valid,
    input  logic            req1_write,
    input  logic [AW-1:0]   req1_address,
    input  logic [SIZE-1:0] req1_write_data,
    output logic            req1_ready,
    output logic            resp1_valid,
    output logic [SIZE-1:0] resp_data,
    output logic            busy,
    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    localparam logic [0:0] ST_ARB = 1'b0;
`ifdef RAM_ARB_INIT_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [0:0] ST_RESET = ST_ARB;
`endif

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic          last;          // port granted most recently
    logic [AW-1:0] addr_held;     // RAM address kept stable while idle
    logic          resp0_pending;
    logic          resp1_pending;
    logic          arb_open;
    logic          acc0;
    logic          acc1;
`ifdef RAM_ARB_INIT_CLEAR_EN
    logic [AW-1:0] clr_addr;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant and RAM drive; reset gates every handshake output immediately
    always_comb begin
        state_next     = state;
        arb_open       = !rst && (state == ST_ARB);
        req0_ready     = arb_open && (!req1_valid || last);
        req1_ready     = arb_open && (!req0_valid || !last);
        acc0           = req0_valid && req0_ready;
        acc1           = req1_valid && req1_ready;
        busy           = rst || (state != ST_ARB);
        ram_address    = acc1 ? req1_address : (acc0 ? req0_address : addr_held);
        ram_write_data = acc1 ? req1_write_data : req0_write_data;
        ram_write_en   = (acc0 && req0_write) || (acc1 && req1_write);
        resp0_valid    = resp0_pending && !rst;
        resp1_valid    = resp1_pending && !rst;
        resp_data      = ram_read_data;
`ifdef RAM_ARB_INIT_CLEAR_EN
        if (state == ST_CLEAR) begin
            ram_address    = clr_addr;
            ram_write_data = '0;
            ram_write_en   = !rst;
            if (clr_addr == AW'(DEPTH - 1)) begin
                state_next = ST_ARB;
            end
        end
`endif
    end

    // Round-robin history, held address and one-cycle read response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            last          <= 1'b1;
            addr_held     <= '0;
            resp0_pending <= 1'b0;
            resp1_pending <= 1'b0;
        end else begin
            if (acc0 || acc1) begin
                last <= acc1;
            end
            addr_held     <= ram_address;
            resp0_pending <= acc0 && !req0_write;
            resp1_pending <= acc1 && !req1_write;
        end
    end

`ifdef RAM_ARB_INIT_CLEAR_EN
    // Clear sweep address, restarted from zero by every reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + AW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM.
// Expectations follow RAM_ARB_INIT_CLEAR_EN when the bench is built with it.
module tb_ram_port_arbiter;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
`ifdef RAM_ARB_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    // Contents of a location the clients never wrote since the last reset
    localparam logic [7:0] FRESH = CLR ? 8'h00 : 8'hFF;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_write, req0_ready, resp0_valid;
    logic [AW-1:0]   req0_address;
    logic [SIZE-1:0] req0_write_data;
    logic            req1_valid, req1_write, req1_ready, resp1_valid;
    logic [AW-1:0]   req1_address;
    logic [SIZE-1:0] req1_write_data;
    logic [SIZE-1:0] resp_data;
    logic            busy;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data;

    logic [SIZE-1:0] mem [DEPTH];
    logic            preload;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
        .req0_write_data(req0_write_data), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
        .req1_write_data(req1_write_data), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
        .resp_data(resp_data), .busy(busy),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
    );

    // Synchronous single-port RAM, read-before-write, preloadable with 0xFF
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
        end else if (ram_write_en) begin
            mem[ram_address] <= ram_write_data;
        end
        ram_read_data <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Called right after rst falls; covers the optional clear sweep
    task automatic release_checks();
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                settle();
                chk("clr_busy", busy, 1);
                chk("clr_ready0", req0_ready, 0);
                chk("clr_ready1", req1_ready, 0);
                chk("clr_we", ram_write_en, 1);
                chk("clr_addr", ram_address, i);
                chk("clr_wdata", ram_write_data, 0);
                tick();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; preload = 1'b1;
        req0_valid = 0; req0_write = 0; req0_address = '0; req0_write_data = '0;
        req1_valid = 0; req1_write = 0; req1_address = '0; req1_write_data = '0;
        tick();
        preload = 1'b0;
        // A write presented during reset must be ignored
        req0_valid = 1; req0_write = 1; req0_address = 4'd5; req0_write_data = 8'h77;
        settle();
        chk("rst_busy", busy, 1);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_we", ram_write_en, 0);
        chk("rst_resp0", resp0_valid, 0);
        chk("rst_resp1", resp1_valid, 0);
        tick();
        req0_valid = 0;
        tick();
        rst = 1'b0;
        release_checks();

        // Untouched / cleared contents at both address extremes
        req0_valid = 1; req0_write = 0; req0_address = 4'd0;
        settle();
        chk("rel_busy", busy, 0);
        chk("rd0_ready0", req0_ready, 1);
        chk("rd0_addr", ram_address, 0);
        chk("rd0_we", ram_write_en, 0);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_write = 0; req1_address = 4'd15;
        settle();
        chk("rd0_resp0", resp0_valid, 1);
        chk("rd0_data", resp_data, FRESH);
        chk("rd15_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        settle();
        chk("rd15_resp1", resp1_valid, 1);
        chk("rd15_data", resp_data, FRESH);
        chk("rd15_resp0", resp0_valid, 0);
        tick();

        // Port 0 writes 0xA5 @3, then reads it back
        req0_valid = 1; req0_write = 1; req0_address = 4'd3; req0_write_data = 8'hA5;
        settle();
        chk("t1w_ready0", req0_ready, 1);
        chk("t1w_we", ram_write_en, 1);
        chk("t1w_addr", ram_address, 3);
        chk("t1w_wdata", ram_write_data, 8'hA5);
        tick();
        req0_write = 0;
        settle();
        chk("t1r_ready0", req0_ready, 1);
        chk("t1r_we", ram_write_en, 0);
        chk("t1r_resp0_early", resp0_valid, 0);
        tick();
        req0_valid = 0;
        settle();
        chk("t1_resp0", resp0_valid, 1);
        chk("t1_data", resp_data, 8'hA5);
        chk("t1_resp1", resp1_valid, 0);
        tick();
        settle();
        chk("t1_resp0_once", resp0_valid, 0);

        // Seed @1=0x11 and @2=0x22, then both ports hold reads: grants 0,1,0,1
        req0_valid = 1; req0_write = 1; req0_address = 4'd1; req0_write_data = 8'h11;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_write = 1; req1_address = 4'd2; req1_write_data = 8'h22;
        tick();
        req0_valid = 1; req0_write = 0; req0_address = 4'd1;
        req1_valid = 1; req1_write = 0; req1_address = 4'd2;
        settle();
        chk("t2a_ready0", req0_ready, 1);
        chk("t2a_ready1", req1_ready, 0);
        chk("t2a_addr", ram_address, 1);
        tick();
        settle();
        chk("t2b_resp0", resp0_valid, 1);
        chk("t2b_data", resp_data, 8'h11);
        chk("t2b_ready0", req0_ready, 0);
        chk("t2b_ready1", req1_ready, 1);
        chk("t2b_addr", ram_address, 2);
        tick();
        settle();
        chk("t2c_resp1", resp1_valid, 1);
        chk("t2c_resp0", resp0_valid, 0);
        chk("t2c_data", resp_data, 8'h22);
        chk("t2c_ready0", req0_ready, 1);
        tick();
        settle();
        chk("t2d_resp0", resp0_valid, 1);
        chk("t2d_data", resp_data, 8'h11);
        chk("t2d_ready1", req1_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        settle();
        chk("t2e_resp1", resp1_valid, 1);
        chk("t2e_resp0", resp0_valid, 0);
        chk("t2e_data", resp_data, 8'h22);
        tick();
        settle();
        chk("t2f_resp0", resp0_valid, 0);
        chk("t2f_resp1", resp1_valid, 0);

        // Make last = 0, then p1 write 0x3C @7 contends with p0 read @7
        req0_valid = 1; req0_write = 1; req0_address = 4'd7; req0_write_data = 8'h55;
        tick();
        req0_write = 0;
        req1_valid = 1; req1_write = 1; req1_address = 4'd7; req1_write_data = 8'h3C;
        settle();
        chk("t3a_ready1", req1_ready, 1);
        chk("t3a_ready0", req0_ready, 0);
        chk("t3a_we", ram_write_en, 1);
        chk("t3a_addr", ram_address, 7);
        chk("t3a_wdata", ram_write_data, 8'h3C);
        tick();
        req1_valid = 0;
        settle();
        chk("t3b_ready0", req0_ready, 1);
        chk("t3b_we", ram_write_en, 0);
        tick();
        req0_valid = 0;
        settle();
        chk("t3c_resp0", resp0_valid, 1);
        chk("t3c_data", resp_data, 8'h3C);
        tick();

        // Idle: no writes, no responses, address held at the last grant
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("idle_we", ram_write_en, 0);
            chk("idle_resp0", resp0_valid, 0);
            chk("idle_resp1", resp1_valid, 0);
            chk("idle_addr", ram_address, 7);
            tick();
        end
        req1_valid = 1; req1_write = 0; req1_address = 4'd3;
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_write = 0; req0_address = 4'd5;
        settle();
        chk("idle_rd3_resp1", resp1_valid, 1);
        chk("idle_rd3_data", resp_data, 8'hA5);
        tick();
        req0_valid = 0;
        settle();
        chk("rd5_resp0", resp0_valid, 1);
        chk("rd5_data", resp_data, FRESH);
        tick();

        // Reset in the cycle after a read accept drops the response
        req0_valid = 1; req0_write = 0; req0_address = 4'd1;
        settle();
        chk("t4_ready0", req0_ready, 1);
        tick();
        rst = 1'b1; req0_valid = 0;
        req1_valid = 1; req1_write = 1; req1_address = 4'd9; req1_write_data = 8'hEE;
        settle();
        chk("t4_resp0", resp0_valid, 0);
        chk("t4_we", ram_write_en, 0);
        chk("t4_busy", busy, 1);
        chk("t4_ready0", req0_ready, 0);
        chk("t4_ready1", req1_ready, 0);
        tick();
        req1_valid = 0;
        tick();
        rst = 1'b0;
        release_checks();
        req0_valid = 1; req0_write = 0; req0_address = 4'd3;
        req1_valid = 1; req1_write = 0; req1_address = 4'd9;
        settle();
        chk("t4_rel_busy", busy, 0);
        chk("t4c_ready0", req0_ready, 1);
        chk("t4c_ready1", req1_ready, 0);
        tick();
        settle();
        chk("t4c_resp0", resp0_valid, 1);
        chk("t4c_data", resp_data, CLR ? 8'h00 : 8'hA5);
        chk("t4c_ready1b", req1_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        settle();
        chk("t4c_resp1", resp1_valid, 1);
        chk("t4c_data9", resp_data, FRESH);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
